// File: rtl/gray_bcd_pkg.sv
// ============================================================================
// gray_bcd_pkg : shared types and helpers for the Gray/BCD receive path
// Rev 1.0
// ============================================================================
`default_nettype none

package gray_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ARMED  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_bcd_sync_filter.sv
// ============================================================================
// gray_bcd_sync_filter : 2-flop synchroniser and stability filter that emits a
// one-cycle accept strobe once a Gray value has held STABLE_CYCLES cycles.
// Rev 1.0
// ============================================================================
`default_nettype none

module gray_bcd_sync_filter #(
    parameter int STABLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic [3:0] gray_i,
    output logic       accept_o,
    output logic [3:0] gray_o
);

    localparam logic [4:0] C_TARGET = 5'(STABLE_CYCLES);

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] last_q, last_d;
    logic [4:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            last_q  <= 4'd0;
            cnt_q   <= 5'd0;
        end else begin
            sync1_q <= gray_i;
            sync2_q <= sync1_q;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // The count parks at C_TARGET+1 so each stable run strobes exactly once.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (clear_i) begin
            cnt_d  = 5'd0;
            last_d = sync2_q;
        end else if (sync2_q != last_q) begin
            cnt_d  = 5'd1;
            last_d = sync2_q;
        end else if (cnt_q <= C_TARGET) begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    assign accept_o = !clear_i && (sync2_q == last_q) && (cnt_q == C_TARGET);
    assign gray_o   = last_q;

endmodule

`default_nettype wire

// File: rtl/gray_bcd_rx.sv
// ============================================================================
// gray_bcd_rx : clocked receiver for asynchronous Gray-coded digits with
// step/range checking, BCD conversion and a valid/ready output.
// Optional error counter enabled by macro GRAY_BCD_RX_ERR_COUNT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module gray_bcd_rx
    import gray_bcd_pkg::*;
#(
    parameter int STABLE_CYCLES = 3,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [3:0]           gray_in,
    output logic [3:0]           out_bcd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 step_err,
    output logic                 range_err,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_e     state_q, state_d;
    logic [3:0] base_q, base_d;
    logic [3:0] bcd_q, bcd_d;
    logic       valid_q, valid_d;
    logic       step_q, step_d;
    logic       range_q, range_d;
    logic       ovr_q, ovr_d;

    logic       filt_accept;
    logic [3:0] filt_gray;
    logic [3:0] filt_bin;
    logic       in_range;
    logic       accept;

    gray_bcd_sync_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_q == IDLE),
        .gray_i   (gray_in),
        .accept_o (filt_accept),
        .gray_o   (filt_gray)
    );

    assign filt_bin = gray2bin(filt_gray);
    assign in_range = (filt_bin <= BCD_MAX);

    // SETTLE takes any stable value as baseline; ARMED only takes changes.
    assign accept = enable && filt_accept &&
                    ((state_q == SETTLE) || ((state_q == ARMED) && (filt_gray != base_q)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= 4'd0;
            bcd_q   <= 4'd0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            range_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            range_q <= range_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        range_d = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            IDLE:    state_d = SETTLE;
            SETTLE:  if (accept) state_d = ARMED;
            ARMED:   state_d = ARMED;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            base_d  = filt_gray;
            range_d = !in_range;
            step_d  = (state_q == ARMED) && (popcount4(filt_gray ^ base_q) != 3'd1);
            if (in_range) begin
                bcd_d   = filt_bin;
                valid_d = 1'b1;
                ovr_d   = valid_q && !out_ready;
            end else if (valid_q && out_ready) begin
                valid_d = 1'b0;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (!enable) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    assign out_bcd   = bcd_q;
    assign out_valid = valid_q;
    assign step_err  = step_q;
    assign range_err = range_q;
    assign overrun   = ovr_q;

`ifdef GRAY_BCD_RX_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if ((step_d || range_d || ovr_d) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/gray_bcd_rx.md
Name: gray_bcd_rx

Overview:
- Receive side of the team's Gray/BCD path: samples a 4-bit Gray-coded digit driven asynchronously from off-clock logic (absolute encoder or the Gray-coded output of the converter).
- Synchronises, deglitches, checks the Gray single-step property and converts to BCD.
- Presents each accepted digit on a valid/ready interface to downstream display and counter logic.
- Counterpart of the combinational converter: the clocked receiver for Gray-coded digit streams.

Parameters:
- STABLE_CYCLES, 3, consecutive synchronised cycles a value must hold before acceptance (legal 1..15).
- ERR_CNT_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- enable  in  1  receiver enable; low forces IDLE.
- gray_in  in  4  asynchronous Gray-coded digit.
- out_bcd  out  4  accepted digit in BCD (binary 0..9).
- out_valid  out  1  out_bcd holds an unconsumed digit.
- out_ready  in  1  downstream accepts; transfer on out_valid && out_ready at a rising edge.
- step_err  out  1  one-cycle pulse: accepted value differs from the previous accepted value in more than one bit.
- range_err  out  1  one-cycle pulse: accepted value decodes to 10..15.
- overrun  out  1  one-cycle pulse: new digit overwrote an unconsumed one.
- err_count  out  ERR_CNT_W  saturating error count (see Optional Feature).

Behaviour:
- Reset values:
  - Outputs: out_bcd=0, out_valid=0, step_err=0, range_err=0, overrun=0, err_count=0.
  - Internal: synchroniser=0, state=IDLE.
- Synchroniser:
  - Two flops on gray_in, always running, including in IDLE.
- Stability filter:
  - Counter clears whenever the synchronised value changes.
  - A value is accepted once it has held STABLE_CYCLES cycles and differs from the last accepted value.
  - Latency: gray_in stable from edge N gives out_valid high after edge N+2+STABLE_CYCLES. This is 5 cycles at the default.
  - A glitch shorter than STABLE_CYCLES is never accepted.
- Decode:
  - b3=g3; b2=b3^g2; b1=b2^g1; b0=b1^g0.
- FSM states: IDLE, SETTLE, ARMED.
- IDLE:
  - Outputs quiescent; out_valid forced 0.
  - enable=1 moves to SETTLE next cycle.
- SETTLE:
  - The first accepted value becomes the baseline. No step check is made on it.
  - If it decodes to 0..9, it is emitted.
  - If it decodes to 10..15, range_err pulses and the baseline is still recorded.
  - Then go to ARMED.
- ARMED, on each accepted value:
  - The value always becomes the new baseline.
  - Popcount(new^old) != 1 pulses step_err; the value is still emitted if in range.
  - Decoded value > 9 pulses range_err and the value is not emitted. If both errors apply, both pulse in the same cycle.
- enable low in any state:
  - Returns to IDLE next edge and clears out_valid.
  - Any pending digit is discarded; the baseline is forgotten.
- Handshake:
  - out_valid stays high until a transfer occurs.
  - out_bcd is stable while out_valid=1 && out_ready=0, unless an overrun occurs.
  - Transfer and new acceptance in the same cycle: the new digit is loaded, out_valid stays 1, no overrun.
  - Acceptance while a digit is pending and out_ready=0: overwrite out_bcd, pulse overrun.
- err_count:
  - Increments by 1 per cycle in which any of step_err, range_err or overrun pulses.
  - Saturates at all-ones; cleared only by reset.
- Reset mid-operation: all state returns to reset values immediately, including the filter count.

Optional Feature:
- Macro GRAY_BCD_RX_ERR_COUNT_EN.
- Defined: err_count implemented as above.
- Undefined: counter logic absent; err_count tied to 0. Ports and all pulses are unchanged.

Decomposition:
- Package gray_bcd_pkg holds:
  - state enum (IDLE, SETTLE, ARMED);
  - BCD_MAX=9 constant;
  - gray2bin function;
  - 4-bit popcount function.
- Natural sub-module gray_bcd_sync_filter: 2-flop synchroniser plus stability counter. It outputs a one-cycle accept strobe and the stable Gray value.

Test Plan:
- Reset, enable=1, gray_in=0110 steady -> out_valid rises 5 cycles after sync start with out_bcd=0100; no error pulses.
- Walk gray_in 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101 at 8-cycle spacing, out_ready=1 -> out_bcd 0..9 in order; step_err never asserts.
- gray_in 0001 -> 0010 (two-bit jump) -> step_err pulses once; out_bcd=0011 still emitted; err_count=1.
- gray_in 1111 (decodes 10) -> range_err pulses; out_valid stays 0; the next legal value 1110 is rejected as out-of-range with no step_err pulse.
- Hold out_ready=0 through two accepted digits -> overrun pulses once; out_bcd holds the second; one transfer when out_ready rises.
- Glitch gray_in for 2 cycles (STABLE_CYCLES=3) -> no acceptance. Drop enable with a pending digit -> out_valid=0 next cycle. Assert rst_n=0 mid-filter -> all outputs 0 asynchronously.
